// File: rtl/d_ff.sv
// rtl/d_ff.sv - parameterised D flip-flop with complemented output; optional clock enable under DFF_CE_EN
module d_ff #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    input  logic             clk,
    input  logic             rst
`ifdef DFF_CE_EN
    ,
    input  logic             ce
`endif
);

    // Power-up value matches the reset value so the outputs are defined
    // from time zero, before any reset edge has been seen.
    logic [WIDTH-1:0] q_reg = RESET_VALUE;

    // Capture path: synchronous reset wins over data and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RESET_VALUE;
`ifdef DFF_CE_EN
        end else if (ce) begin
            q_reg <= D;
`else
        end else begin
            q_reg <= D;
`endif
        end
    end

    // Qbar is derived from the single stored copy so Q and Qbar can never disagree.
    assign Q    = q_reg;
    assign Qbar = ~q_reg;

endmodule

// File: tb/tb_d_ff.sv
// tb/tb_d_ff.sv - scoreboard bench for d_ff (WIDTH=1 default and WIDTH=8, RESET_VALUE=8'hA5)
module tb_d_ff;

`ifdef DFF_CE_EN
    localparam bit CE_EN = 1'b1;
`else
    localparam bit CE_EN = 1'b0;
`endif

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       D1;
    logic       Q1, Qb1;
    logic [7:0] D8;
    logic [7:0] Q8, Qb8;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    exp_t exp_q[$];

    logic       m1;
    logic [7:0] m8;

    d_ff u_dut1 (
        .D    (D1),
        .Q    (Q1),
        .Qbar (Qb1),
        .clk  (clk),
        .rst  (rst)
`ifdef DFF_CE_EN
        ,
        .ce   (ce)
`endif
    );

    d_ff #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .D    (D8),
        .Q    (Q8),
        .Qbar (Qb8),
        .clk  (clk),
        .rst  (rst)
`ifdef DFF_CE_EN
        ,
        .ce   (ce)
`endif
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour: reset loads the reset value, otherwise an enabled edge loads D, else hold.
    function automatic logic [7:0] next_q(input logic [7:0] cur, input logic r, input logic c,
                                          input logic [7:0] d, input logic [7:0] rv, input int w);
        logic [7:0] mask;
        logic [7:0] n;
        mask = 8'((16'd1 << w) - 16'd1);
        if (r)       n = rv;
        else if (c)  n = d;
        else         n = cur;
        return n & mask;
    endfunction

    // Monitor: every rising edge produces a new output; compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check8("q_w1",    {7'd0, Q1},  {7'd0, e.e1});
            check8("qbar_w1", {7'd0, Qb1}, {7'd0, ~e.e1});
            check8("q_w8",    Q8,  e.e8);
            check8("qbar_w8", Qb8, ~e.e8);
        end
    end

    task automatic drive_cycle(input logic r, input logic c, input logic d1, input logic [7:0] d8,
                               input bit pulse);
        logic c_eff;
        @(negedge clk);
        if (pulse) begin
            rst = 1'b1;
            #2;
            check8("async_w1", {7'd0, Q1}, {7'd0, m1});
            check8("async_w8", Q8, m8);
            rst = 1'b0;
            #1;
        end
        // Scribble on D between edges; only the value present at the edge matters.
        D1 = ~d1;
        D8 = ~d8;
        #1;
        rst = r;
        ce  = c;
        D1  = d1;
        D8  = d8;
        c_eff = CE_EN ? c : 1'b1;
        m1 = next_q({7'd0, m1}, r, c_eff, {7'd0, d1}, 8'd0, 1) != 8'd0;
        m8 = next_q(m8, r, c_eff, d8, RV8, 8);
        exp_q.push_back('{e1: m1, e8: m8});
    endtask

    initial begin
        logic [6:0] seq;
        rst = 1'b1;
        ce  = 1'b0;
        D1  = 1'b1;
        D8  = 8'h3C;
        #1;
        check8("powerup_q_w1",    {7'd0, Q1},  8'h00);
        check8("powerup_qbar_w1", {7'd0, Qb1}, 8'h01);
        check8("powerup_q_w8",    Q8,  RV8);
        check8("powerup_qbar_w8", Qb8, 8'h5A);

        // First edge at t=5 is a reset with D=1 and ce=0.
        m1 = 1'b0;
        m8 = RV8;
        exp_q.push_back('{e1: 1'b0, e8: RV8});

        // Release reset, capture D=1 / 8'h3C on the following edge.
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);

        // Directed sequence 0,0,0,1,1,1,0.
        seq = 7'b0111000;
        for (int i = 0; i < 7; i++)
            drive_cycle(1'b0, 1'b1, seq[i], {8{seq[i]}}, 1'b0);

        // Async pulse between edges must not disturb Q.
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h81, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h7E, 1'b1);

        // Enable low for three clocks with D toggling, then enable, then reset with ce low.
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h11, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h22, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            drive_cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                        1'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
